mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Used when fetch and data access are split into separate units (pipelined core).
- Valid/ready request channel per requester. Downstream memory is pipelined, so responses return in order.
- A small ID FIFO records which port issued each outstanding request and routes each response back to it.

Parameters:
- MAX_OUTSTANDING, 2, depth of the ID FIFO (power of two, at least 1); maximum requests issued but not yet answered.
- FIXED_PRIORITY, 0, 0 selects round-robin; 1 makes port 1 always win.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-low
- req_valid_i  in  2  per-port request valid
- req_ready_o  out  2  per-port request accepted this cycle
- req_we_i  in  2  per-port write enable
- req_addr_i  in  2x32  per-port address
- req_wdata_i  in  2x32  per-port write data
- req_size_i  in  2x2  per-port access size (mem size encoding)
- resp_valid_o  out  2  per-port response valid
- resp_rdata_o  out  32  response data, shared by both ports; qualified by resp_valid_o
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream accepts request
- mem_we_o  out  1  downstream write enable
- mem_addr_o  out  32  downstream address
- mem_wdata_o  out  32  downstream write data
- mem_size_o  out  2  downstream access size
- mem_resp_valid_i  in  1  downstream response valid (one per request, in order, writes included)
- mem_resp_rdata_i  in  32  downstream read data (don't-care for writes)
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  number of entries in the ID FIFO
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (reset_i==0 at clk edge):
  - FIFO emptied; outstanding_o=0; err_o=0; lock cleared; rr_ptr=0.
  - While reset_i is low, req_ready_o, resp_valid_o and mem_req_valid_o are forced to 0.
  - A mid-operation reset discards all in-flight IDs. The downstream memory must be reset alongside.
- can_issue = (count < MAX_OUTSTANDING) || pop_this_cycle.
- Winner selection is combinational:
  - If locked: winner = lock_port.
  - Else if FIXED_PRIORITY: port 1 if valid, otherwise port 0.
  - Else (round-robin): port rr_ptr if valid, otherwise the other port.
- mem_req_valid_o = can_issue && req_valid_i[winner]. The mem_* outputs are muxed combinationally from the winner's inputs.
- Handshake: fire = mem_req_valid_o && mem_req_ready_i.
  - req_ready_o[winner] = fire; the other bit is 0. Zero added latency.
- On fire:
  - Push winner into the FIFO.
  - Clear lock.
  - rr_ptr <= ~winner.
- Lock: mem_req_valid_o && !mem_req_ready_i sets lock=1 and lock_port=winner. A higher-priority request arriving later must not change the presented request until fire.
- Requesters hold valid and payload stable until ready.
  - If req_valid_i[lock_port] drops while locked, set err_o and clear lock.
- Response: mem_resp_valid_i with FIFO non-empty gives resp_valid_o[head]=1 and resp_rdata_o=mem_resp_rdata_i in the same cycle (combinational), then pops.
  - Responses are never buffered; requesters must accept them in that cycle.
- mem_resp_valid_i with FIFO empty: ignored, err_o set (sticky until reset).
- Push and pop in the same cycle: count is unchanged. This is allowed when full (can_issue=1 via pop).
- The downstream response for a request arrives at the earliest on the cycle after its fire.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Count is tracked separately to distinguish full from empty.

Decomposition:
- Shared definitions package: arb_port_t enum (ARB_PORT_FETCH=0, ARB_PORT_DATA=1), mem size typedef, ARB_NUM_PORTS=2.
- Sub-module arb_id_fifo (parameter DEPTH, data type arb_port_t; push/pop/head/count; same-cycle push and pop when full).
- Arbitration, lock and rr_ptr stay in mem_port_arbiter.

Test Plan:
- Reset release, port 0 read at 0x00010000, mem_req_ready_i=1, response 0xDEADBEEF one cycle later -> req_ready_o=01 at cycle 0, resp_valid_o=01 with rdata 0xDEADBEEF, outstanding_o returns to 0.
- Both ports valid every cycle, always ready, round-robin -> grants alternate 0,1,0,1 starting with port 0. With FIXED_PRIORITY=1 -> port 1 granted every cycle; port 0 starves.
- Port 0 presented, mem_req_ready_i=0 for 3 cycles, port 1 raises valid in cycle 1 -> mem_addr_o stays port 0's address until fire; port 1 granted next.
- MAX_OUTSTANDING=2, no responses -> third request stalls (mem_req_valid_o=0, outstanding_o=2). Response in the same cycle as the third request -> third request fires, count stays 2.
- Interleaved issue 0,1,1, responses A,B,C -> routed to ports 0,1,1 in order. Port 1 write gets resp_valid_o.
- Spurious mem_resp_valid_i with the FIFO empty -> err_o=1 stays set. Reset mid-traffic (2 outstanding) -> outstanding_o=0, err_o=0 the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

    localparam int ARB_NUM_PORTS = 2;

    // Requester identity; also the payload stored in the ID FIFO.
    typedef enum logic {
        ARB_PORT_FETCH = 1'b0,
        ARB_PORT_DATA  = 1'b1
    } arb_port_t;

    // Memory access size encoding, passed through untouched.
    typedef logic [1:0] mem_size_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Small FIFO of port IDs for outstanding memory requests.
// Supports push and pop in the same cycle, including when full.
module arb_id_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  arb_port_t                push_data_i,
    input  logic                     pop_i,
    output arb_port_t                head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    arb_port_t              mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    // Pointers wrap at DEPTH explicitly so DEPTH=1 also works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one pipelined memory port between instruction fetch (port 0)
// and data access (port 1). Responses return in order and are routed back
// using the ID FIFO. A presented request is locked until it is accepted.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIXED_PRIORITY  = 0
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [ARB_NUM_PORTS-1:0]              req_valid_i,
    output logic [ARB_NUM_PORTS-1:0]              req_ready_o,
    input  logic [ARB_NUM_PORTS-1:0]              req_we_i,
    input  logic [ARB_NUM_PORTS-1:0][31:0]        req_addr_i,
    input  logic [ARB_NUM_PORTS-1:0][31:0]        req_wdata_i,
    input  logic [ARB_NUM_PORTS-1:0][1:0]         req_size_i,
    output logic [ARB_NUM_PORTS-1:0]              resp_valid_o,
    output logic [31:0]                           resp_rdata_o,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output logic                                  mem_we_o,
    output logic [31:0]                           mem_addr_o,
    output logic [31:0]                           mem_wdata_o,
    output mem_size_t                             mem_size_o,
    input  logic                                  mem_resp_valid_i,
    input  logic [31:0]                           mem_resp_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
    output logic                                  err_o
);

    arb_port_t  winner;
    logic       win_idx;
    logic       rr_idx;
    logic       lock_idx;
    logic       head_idx;

    arb_port_t  rr_ptr_q, rr_ptr_d;
    logic       lock_q, lock_d;
    arb_port_t  lock_port_q, lock_port_d;
    logic       err_q, err_d;

    logic       fire;
    logic       pop;
    logic       can_issue;
    logic       lock_drop;
    logic       spurious_resp;

    arb_port_t  fifo_head;
    logic       fifo_empty;
    logic       fifo_full;

    assign rr_idx   = rr_ptr_q;
    assign lock_idx = lock_port_q;
    assign head_idx = fifo_head;

    // Winner selection: a locked request always keeps the port.
    always_comb begin
        winner = rr_ptr_q;
        if (lock_q) begin
            winner = lock_port_q;
        end else if (FIXED_PRIORITY != 0) begin
            winner = req_valid_i[1] ? ARB_PORT_DATA : ARB_PORT_FETCH;
        end else begin
            winner = req_valid_i[rr_idx] ? rr_ptr_q : arb_port_t'(~rr_ptr_q);
        end
    end

    assign win_idx = winner;

    // Responses pop the FIFO; a full FIFO may still issue if it pops this cycle.
    assign pop           = reset_i && mem_resp_valid_i && !fifo_empty;
    assign spurious_resp = mem_resp_valid_i && fifo_empty;
    assign can_issue     = !fifo_full || pop;

    assign mem_req_valid_o = reset_i && can_issue && req_valid_i[win_idx];
    assign fire            = mem_req_valid_o && mem_req_ready_i;

    assign mem_we_o    = req_we_i[win_idx];
    assign mem_addr_o  = req_addr_i[win_idx];
    assign mem_wdata_o = req_wdata_i[win_idx];
    assign mem_size_o  = req_size_i[win_idx];

    // Ready and response routing, one-hot on the selected port.
    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        req_ready_o[win_idx] = fire;
        if (pop) resp_valid_o[head_idx] = 1'b1;
    end

    assign resp_rdata_o = mem_resp_rdata_i;

    // Next-state for lock, round-robin pointer and sticky error.
    always_comb begin
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        rr_ptr_d    = rr_ptr_q;
        lock_drop   = 1'b0;
        if (fire) begin
            lock_d   = 1'b0;
            rr_ptr_d = arb_port_t'(~winner);
        end else if (mem_req_valid_o) begin
            lock_d      = 1'b1;
            lock_port_d = winner;
        end else if (lock_q && !req_valid_i[lock_idx]) begin
            lock_d    = 1'b0;
            lock_drop = 1'b1;
        end
        err_d = err_q || lock_drop || spurious_resp;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            lock_q      <= 1'b0;
            lock_port_q <= ARB_PORT_FETCH;
            rr_ptr_q    <= ARB_PORT_FETCH;
            err_q       <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (fire),
        .push_data_i (winner),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (outstanding_o)
    );

    assign err_o = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a grant/response scoreboard.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance
    logic             rst_n;
    logic [1:0]       rv, rdy, we, resp_v;
    logic [1:0][31:0] addr, wdata;
    logic [1:0][1:0]  size;
    logic [31:0]      rdata;
    logic             mreq_v, mrdy, mwe, mresp_v;
    logic [31:0]      maddr, mwdata, mresp_d;
    logic [1:0]       msize;
    logic [1:0]       outst;
    logic             err;

    // Fixed-priority instance
    logic             rst2_n;
    logic [1:0]       rv2, rdy2, resp_v2;
    logic [1:0][31:0] addr2;
    logic [31:0]      rdata2;
    logic             mreq_v2, mrdy2, mwe2, mresp_v2;
    logic [31:0]      maddr2, mwdata2;
    logic [1:0]       msize2;
    logic [1:0]       outst2;
    logic             err2;

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIORITY(0)) dut (
        .clk_i(clk), .reset_i(rst_n),
        .req_valid_i(rv), .req_ready_o(rdy), .req_we_i(we),
        .req_addr_i(addr), .req_wdata_i(wdata), .req_size_i(size),
        .resp_valid_o(resp_v), .resp_rdata_o(rdata),
        .mem_req_valid_o(mreq_v), .mem_req_ready_i(mrdy), .mem_we_o(mwe),
        .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_size_o(msize),
        .mem_resp_valid_i(mresp_v), .mem_resp_rdata_i(mresp_d),
        .outstanding_o(outst), .err_o(err)
    );

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIORITY(1)) dut_fp (
        .clk_i(clk), .reset_i(rst2_n),
        .req_valid_i(rv2), .req_ready_o(rdy2), .req_we_i(2'b00),
        .req_addr_i(addr2), .req_wdata_i(64'h0), .req_size_i(4'h0),
        .resp_valid_o(resp_v2), .resp_rdata_o(rdata2),
        .mem_req_valid_o(mreq_v2), .mem_req_ready_i(mrdy2), .mem_we_o(mwe2),
        .mem_addr_o(maddr2), .mem_wdata_o(mwdata2), .mem_size_o(msize2),
        .mem_resp_valid_i(mresp_v2), .mem_resp_rdata_i(32'h0),
        .outstanding_o(outst2), .err_o(err2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // {port, addr} of each expected grant; {port, data} of each expected response
    logic [32:0] grant_q[$];
    logic [32:0] resp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted request and every response to the scoreboard.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (mreq_v && mrdy) begin
                    if (grant_q.size() == 0) begin
                        check("grant_unexpected", {30'b0, rdy}, 32'h0);
                    end else begin
                        e = grant_q.pop_front();
                        check("grant_port", {30'b0, rdy}, e[32] ? 32'h2 : 32'h1);
                        check("grant_addr", maddr, e[31:0]);
                    end
                end
                if (resp_v != 2'b00) begin
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", {30'b0, resp_v}, 32'h0);
                    end else begin
                        e = resp_q.pop_front();
                        check("resp_port", {30'b0, resp_v}, e[32] ? 32'h2 : 32'h1);
                        check("resp_data", rdata, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; rv = 2'b11; we = 2'b00; addr = '0; wdata = '0; size = '0;
        mrdy = 1'b1; mresp_v = 1'b0; mresp_d = '0;
        rst2_n = 1'b0; rv2 = 2'b00; addr2 = '0; mrdy2 = 1'b1; mresp_v2 = 1'b0;

        // Reset: outputs forced low even with requests pending
        tick(); tick();
        @(negedge clk);
        check("rst_ready", {30'b0, rdy}, 32'h0);
        check("rst_mreq_v", {31'b0, mreq_v}, 32'h0);
        check("rst_outstanding", {30'b0, outst}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);

        // Single port-0 read
        tick(); rst_n = 1'b1; rv = 2'b01; addr[0] = 32'h0001_0000; mrdy = 1'b1;
        grant_q.push_back({1'b0, 32'h0001_0000});
        @(negedge clk);
        check("t1_ready", {30'b0, rdy}, 32'h1);
        tick(); rv = 2'b00; mresp_v = 1'b1; mresp_d = 32'hDEAD_BEEF;
        resp_q.push_back({1'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        check("t1_outstanding_1", {30'b0, outst}, 32'h1);
        tick(); mresp_v = 1'b0;
        @(negedge clk);
        check("t1_outstanding_0", {30'b0, outst}, 32'h0);

        // Re-reset so round-robin starts at port 0
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;

        // Round-robin with both ports requesting: grants 0,1,0
        addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            tick();
            rv      = (i < 3) ? 2'b11 : 2'b00;
            mresp_v = (i > 0);
            mresp_d = 32'h0000_1000 + i;
            if (i < 3) grant_q.push_back({i[0], addr[i[0]]});
            if (i > 0) resp_q.push_back({~i[0], 32'h0000_1000 + i});
            @(negedge clk);
            if (i < 3) check("rr_ready", {30'b0, rdy}, i[0] ? 32'h2 : 32'h1);
        end

        // Lock: port 0 stalled, port 1 (preferred by round-robin) arrives later
        tick(); rv = 2'b01; addr[0] = 32'h0000_0300; mrdy = 1'b0; mresp_v = 1'b0;
        @(negedge clk);
        check("lock_c0_addr", maddr, 32'h0000_0300);
        check("lock_c0_ready", {30'b0, rdy}, 32'h0);
        for (int i = 1; i < 3; i++) begin
            tick(); rv = 2'b11; addr[1] = 32'h0000_0400;
            @(negedge clk);
            check("lock_hold_valid", {31'b0, mreq_v}, 32'h1);
            check("lock_hold_addr", maddr, 32'h0000_0300);
        end
        tick(); mrdy = 1'b1;
        grant_q.push_back({1'b0, 32'h0000_0300});
        @(negedge clk);
        check("lock_fire_ready", {30'b0, rdy}, 32'h1);
        tick(); rv = 2'b10; mresp_v = 1'b1; mresp_d = 32'h0000_3333;
        grant_q.push_back({1'b1, 32'h0000_0400});
        resp_q.push_back({1'b0, 32'h0000_3333});
        @(negedge clk);
        check("lock_next_ready", {30'b0, rdy}, 32'h2);
        tick(); rv = 2'b00; mresp_d = 32'h0000_4444;
        resp_q.push_back({1'b1, 32'h0000_4444});

        // Outstanding limit: third request stalls, then fires alongside a response
        tick(); rv = 2'b01; addr[0] = 32'h0000_0500; mresp_v = 1'b0;
        grant_q.push_back({1'b0, 32'h0000_0500});
        tick(); addr[0] = 32'h0000_0504;
        grant_q.push_back({1'b0, 32'h0000_0504});
        @(negedge clk);
        check("full_cnt1", {30'b0, outst}, 32'h1);
        tick(); addr[0] = 32'h0000_0508;
        @(negedge clk);
        check("full_stall_v", {31'b0, mreq_v}, 32'h0);
        check("full_cnt2", {30'b0, outst}, 32'h2);
        tick(); mresp_v = 1'b1; mresp_d = 32'h0000_5000;
        resp_q.push_back({1'b0, 32'h0000_5000});
        grant_q.push_back({1'b0, 32'h0000_0508});
        @(negedge clk);
        check("full_pop_v", {31'b0, mreq_v}, 32'h1);
        tick(); rv = 2'b00; mresp_d = 32'h0000_5004;
        resp_q.push_back({1'b0, 32'h0000_5004});
        @(negedge clk);
        check("full_pushpop_cnt", {30'b0, outst}, 32'h2);
        tick(); mresp_d = 32'h0000_5008;
        resp_q.push_back({1'b0, 32'h0000_5008});
        tick(); mresp_v = 1'b0;
        @(negedge clk);
        check("full_drain_cnt", {30'b0, outst}, 32'h0);

        // Interleaved issue 0,1(write),1 with responses A,B,C
        tick(); rv = 2'b01; addr[0] = 32'h0000_0600;
        grant_q.push_back({1'b0, 32'h0000_0600});
        tick(); rv = 2'b10; we = 2'b10; addr[1] = 32'h0000_0700; wdata[1] = 32'h1234_5678;
        mresp_v = 1'b1; mresp_d = 32'hAAAA_0001;
        grant_q.push_back({1'b1, 32'h0000_0700});
        resp_q.push_back({1'b0, 32'hAAAA_0001});
        @(negedge clk);
        check("wr_we", {31'b0, mwe}, 32'h1);
        check("wr_wdata", mwdata, 32'h1234_5678);
        tick(); we = 2'b00; addr[1] = 32'h0000_0704; mresp_d = 32'hBBBB_0002;
        grant_q.push_back({1'b1, 32'h0000_0704});
        resp_q.push_back({1'b1, 32'hBBBB_0002});
        tick(); rv = 2'b00; mresp_d = 32'hCCCC_0003;
        resp_q.push_back({1'b1, 32'hCCCC_0003});
        tick(); mresp_v = 1'b0;
        @(negedge clk);
        check("il_cnt", {30'b0, outst}, 32'h0);

        // Spurious response with empty FIFO sets sticky error
        tick(); mresp_v = 1'b1; mresp_d = 32'h0000_0BAD;
        @(negedge clk);
        check("spur_resp_v", {30'b0, resp_v}, 32'h0);
        check("spur_err_pre", {31'b0, err}, 32'h0);
        tick(); mresp_v = 1'b0;
        @(negedge clk);
        check("spur_err", {31'b0, err}, 32'h1);
        tick();
        @(negedge clk);
        check("spur_err_sticky", {31'b0, err}, 32'h1);

        // Reset with two requests in flight
        tick(); rv = 2'b11; addr[0] = 32'h0000_0800; addr[1] = 32'h0000_0900;
        grant_q.push_back({1'b0, 32'h0000_0800});
        tick();
        grant_q.push_back({1'b1, 32'h0000_0900});
        tick(); rst_n = 1'b0;
        @(negedge clk);
        check("mid_cnt_before", {30'b0, outst}, 32'h2);
        check("mid_rst_mreq_v", {31'b0, mreq_v}, 32'h0);
        check("mid_rst_ready", {30'b0, rdy}, 32'h0);
        tick(); rst_n = 1'b1; rv = 2'b00;
        @(negedge clk);
        check("mid_cnt_after", {30'b0, outst}, 32'h0);
        check("mid_err_after", {31'b0, err}, 32'h0);

        check("grant_q_empty", grant_q.size(), 32'h0);
        check("resp_q_empty", resp_q.size(), 32'h0);

        // Fixed priority: port 1 wins every cycle, port 0 starves
        addr2[0] = 32'h0000_A000; addr2[1] = 32'h0000_B000;
        for (int i = 0; i < 5; i++) begin
            tick();
            rst2_n   = 1'b1;
            rv2      = (i < 4) ? 2'b11 : 2'b00;
            mresp_v2 = (i > 0);
            @(negedge clk);
            if (i < 4) begin
                check("fp_ready", {30'b0, rdy2}, 32'h2);
                check("fp_addr", maddr2, 32'h0000_B000);
            end
            if (i > 0) check("fp_resp", {30'b0, resp_v2}, 32'h2);
        end
        tick(); mresp_v2 = 1'b0;
        @(negedge clk);
        check("fp_cnt", {30'b0, outst2}, 32'h0);
        check("fp_err", {31'b0, err2}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
